// File: rtl/pipeline_pkg.sv
// Shared types for the 24-bit core pipeline: register tags, operand mux selects
// and the load-use FSM encoding.
package pipeline_pkg;

  localparam int REG_ADDR_W = 4;

  typedef logic [REG_ADDR_W-1:0] regAddr_t;

  typedef struct packed {
    regAddr_t rd;
    logic     we;
    logic     isLoad;
  } stageTag_t;

  localparam stageTag_t BUBBLE_TAG = '0;

  // Operand mux select encodings: {F, lo}
  localparam logic [1:0] SEL_RD     = 2'b00;
  localparam logic [1:0] SEL_ALT    = 2'b01;
  localparam logic [1:0] SEL_ALUOUT = 2'b10;
  localparam logic [1:0] SEL_RESULT = 2'b11;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } luState_t;

  // MEM beats WB; the alternate source (pc / Imm) overrides any forward.
  function automatic logic [1:0] fwd_sel(
    input regAddr_t  rs,
    input logic      rs_used,
    input stageTag_t mem,
    input stageTag_t wb,
    input logic      alt
  );
    logic [1:0] sel;
    sel = SEL_RD;
    if (alt) begin
      sel = SEL_ALT;
    end else if (rs_used && mem.we && (rs == mem.rd)) begin
      sel = SEL_ALUOUT;
    end else if (rs_used && wb.we && (rs == wb.rd)) begin
      sel = SEL_RESULT;
    end
    return sel;
  endfunction

endpackage

// File: rtl/stage_tag_reg.sv
// One pipeline stage worth of destination tag, with bubble insertion.
// Writes to r0 are dropped on capture so r0 can never be forwarded.
module stage_tag_reg
  import pipeline_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      bubble,
  input  stageTag_t d,
  output stageTag_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= BUBBLE_TAG;
    end else if (bubble) begin
      q <= BUBBLE_TAG;
    end else begin
      q.rd     <= d.rd;
      q.we     <= d.we && (d.rd != '0);
      q.isLoad <= d.isLoad;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Tracks in-flight destination tags, drives the EX operand mux selects and
// raises a single-cycle load-use stall toward IF/ID.
//
// state    | meaning
// RUN      | normal issue; a load-use hazard stalls for one cycle
// LU_STALL | bubble just inserted; never stall again this cycle
module hazard_forward_unit
  import pipeline_pkg::*;
#(
  parameter int regAddrW = 4,
  parameter int cntW     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [regAddrW-1:0] idRs1,
  input  logic [regAddrW-1:0] idRs2,
  input  logic [regAddrW-1:0] idRd,
  input  logic                idWe,
  input  logic                idIsLoad,
  input  logic                idUsesRs2,
  input  logic                branchFlag,
  input  logic                immSrc,
  input  logic                flush,
  output logic                Fa,
  output logic                Fb,
  output logic                aLo,
  output logic                bLo,
  output logic                stall,
  output logic [cntW-1:0]     stallCount
);

  stageTag_t ex_d;
  stageTag_t ex_q;
  stageTag_t mem_q;
  stageTag_t wb_q;
  regAddr_t  ex_rs1;
  regAddr_t  ex_rs2;
  logic      ex_uses_rs2;
  logic      ex_bubble;
  logic      hazard;
  luState_t  lu_state;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  assign ex_d.rd     = regAddr_t'(idRd);
  assign ex_d.we     = idWe;
  assign ex_d.isLoad = idIsLoad;

  stage_tag_reg u_ex_tag (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (ex_bubble),
    .d      (ex_d),
    .q      (ex_q)
  );

  stage_tag_reg u_mem_tag (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .d      (ex_q),
    .q      (mem_q)
  );

  stage_tag_reg u_wb_tag (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  // Source fields only matter in EX, so they live here rather than in every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_uses_rs2 <= 1'b0;
    end else if (ex_bubble) begin
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_uses_rs2 <= 1'b0;
    end else begin
      ex_rs1      <= regAddr_t'(idRs1);
      ex_rs2      <= regAddr_t'(idRs2);
      ex_uses_rs2 <= idUsesRs2;
    end
  end

  assign hazard = ex_q.isLoad && ex_q.we &&
                  ((ex_q.rd == regAddr_t'(idRs1)) ||
                   (idUsesRs2 && (ex_q.rd == regAddr_t'(idRs2))));

  // A taken branch kills the consumer anyway, so it wins over the stall.
  assign stall     = (lu_state == RUN) && hazard && !flush;
  assign ex_bubble = stall || flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_state <= RUN;
    end else begin
      case (lu_state)
        RUN:      lu_state <= stall ? LU_STALL : RUN;
        LU_STALL: lu_state <= RUN;
        default:  lu_state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCount <= '0;
    end else if (stall && (stallCount != '1)) begin
      stallCount <= stallCount + 1'b1;
    end
  end

  assign sel_a = fwd_sel(ex_rs1, 1'b1, mem_q, wb_q, branchFlag);
  assign sel_b = fwd_sel(ex_rs2, ex_uses_rs2, mem_q, wb_q, immSrc);

  assign Fa  = sel_a[1];
  assign aLo = sel_a[0];
  assign Fb  = sel_b[1];
  assign bLo = sel_b[0];

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: the driver pushes hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_hazard_forward_unit;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       idRs1, idRs2, idRd;
  logic             idWe, idIsLoad, idUsesRs2;
  logic             branchFlag, immSrc, flush;
  logic             Fa, Fb, aLo, bLo, stall;
  logic [CNT_W-1:0] stallCount;

  typedef struct {
    string            name;
    logic             fa;
    logic             alo;
    logic             fb;
    logic             blo;
    logic             st;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  hazard_forward_unit #(.regAddrW(4), .cntW(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .idRs1      (idRs1),
    .idRs2      (idRs2),
    .idRd       (idRd),
    .idWe       (idWe),
    .idIsLoad   (idIsLoad),
    .idUsesRs2  (idUsesRs2),
    .branchFlag (branchFlag),
    .immSrc     (immSrc),
    .flush      (flush),
    .Fa         (Fa),
    .Fb         (Fb),
    .aLo        (aLo),
    .bLo        (bLo),
    .stall      (stall),
    .stallCount (stallCount)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({Fa, aLo, Fb, bLo, stall} !== {e.fa, e.alo, e.fb, e.blo, e.st} ||
          stallCount !== e.cnt) begin
        n_fail++;
        $display("FAIL %s: got Fa=%b aLo=%b Fb=%b bLo=%b stall=%b cnt=%0d, want Fa=%b aLo=%b Fb=%b bLo=%b stall=%b cnt=%0d",
                 e.name, Fa, aLo, Fb, bLo, stall, stallCount,
                 e.fa, e.alo, e.fb, e.blo, e.st, e.cnt);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish, %0d checks done", n_checks);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                    input logic we, input logic ld, input logic u2);
    idRs1     = rs1;
    idRs2     = rs2;
    idRd      = rd;
    idWe      = we;
    idIsLoad  = ld;
    idUsesRs2 = u2;
  endtask

  task automatic chk(input string nm, input logic fa, input logic alo, input logic fb,
                     input logic blo, input logic st, input logic [CNT_W-1:0] cnt);
    exp_t x;
    x.name = nm;
    x.fa   = fa;
    x.alo  = alo;
    x.fb   = fb;
    x.blo  = blo;
    x.st   = st;
    x.cnt  = cnt;
    sb.push_back(x);
  endtask

  initial begin
    rst_n = 1'b0; branchFlag = 1'b0; immSrc = 1'b0; flush = 1'b0;
    id(0, 0, 0, 0, 0, 0);
    tick(); branchFlag = 1'b1;               chk("reset_vals",        0,1,0,0,0,0);
    tick(); rst_n = 1'b1; branchFlag = 1'b0;
            id(1, 2, 3, 1, 0, 1);            chk("post_reset_idle",   0,0,0,0,0,0);
    tick(); id(3, 4, 5, 1, 0, 1);            chk("add_in_ex",         0,0,0,0,0,0);
    tick(); id(0, 0, 0, 0, 0, 0);            chk("ex_mem_fwd",        1,0,0,0,0,0);
    tick(); id(1, 2, 3, 1, 0, 1);            chk("nop_in_ex",         0,0,0,0,0,0);
    tick(); id(0, 0, 0, 0, 0, 0);            chk("add_r3_ex",         0,0,0,0,0,0);
    tick(); id(3, 3, 6, 1, 0, 1);            chk("gap_nop",           0,0,0,0,0,0);
    tick(); id(1, 2, 3, 1, 0, 1);            chk("ex_wb_fwd",         1,1,1,1,0,0);
    tick();                                  chk("no_fwd_r1r2",       0,0,0,0,0,0);
    tick(); id(3, 3, 8, 1, 0, 1);            chk("two_producers",     0,0,0,0,0,0);
    tick(); id(0, 0, 0, 0, 0, 0);            chk("mem_priority",      1,0,1,0,0,0);
    tick(); id(1, 0, 2, 1, 1, 0);            chk("pre_load",          0,0,0,0,0,0);
    tick(); id(2, 1, 7, 1, 0, 1);            chk("load_use_stall",    0,0,0,0,1,0);
    tick();                                  chk("stall_one_cycle",   0,0,0,0,0,1);
    tick(); id(2, 0, 4, 1, 1, 0);            chk("load_fwd_result",   1,1,0,0,0,1);
    tick(); id(4, 4, 9, 1, 0, 1);            chk("second_stall",      0,0,0,0,1,1);
    tick();                                  chk("no_back_to_back",   0,0,0,0,0,2);
    tick(); id(0, 0, 0, 0, 0, 0);            chk("second_fwd",        1,1,1,1,0,2);
    tick(); id(1, 2, 0, 1, 0, 1);            chk("pre_r0",            0,0,0,0,0,2);
    tick(); id(0, 0, 5, 1, 0, 1);            chk("r0_prod_ex",        0,0,0,0,0,2);
    tick(); id(1, 0, 0, 1, 1, 0);            chk("r0_no_fwd",         0,0,0,0,0,2);
    tick(); id(0, 0, 5, 1, 0, 1);            chk("ld_r0_no_stall",    0,0,0,0,0,2);
    tick(); id(1, 2, 6, 1, 0, 1);            chk("r0_in_mem",         0,0,0,0,0,2);
    tick(); id(6, 6, 10, 1, 0, 1);           chk("add_r6_ex",         0,0,0,0,0,2);
    tick(); immSrc = 1'b1;                   chk("imm_suppress",      1,0,0,1,0,2);
    tick(); immSrc = 1'b0; branchFlag = 1'b1;
            id(0, 0, 0, 0, 0, 0);            chk("branch_suppress",   0,1,1,1,0,2);
    tick(); branchFlag = 1'b0;
            id(1, 2, 11, 1, 0, 1);           chk("pre_flush",         0,0,0,0,0,2);
    tick(); id(11, 0, 2, 1, 1, 0);           chk("add_r11_ex",        0,0,0,0,0,2);
    tick(); id(2, 1, 7, 1, 0, 1); flush = 1'b1;
                                             chk("flush_over_stall",  1,0,0,0,0,2);
    tick(); flush = 1'b0; id(2, 11, 12, 1, 0, 1);
                                             chk("flush_bubble",      0,0,0,0,0,2);
    tick(); id(0, 0, 0, 0, 0, 0);            chk("older_not_killed",  1,1,0,0,0,2);
    tick(); id(1, 0, 2, 1, 1, 0);            chk("pre_load3",         0,0,0,0,0,2);
    tick(); id(2, 1, 7, 1, 0, 1);            chk("third_stall",       0,0,0,0,1,2);
    tick();                                  chk("count_three",       0,0,0,0,0,3);
    tick(); id(1, 0, 2, 1, 1, 0);            chk("third_fwd",         1,1,0,0,0,3);
    tick(); id(2, 1, 7, 1, 0, 1);            chk("stall_at_max",      0,0,0,0,1,3);
    tick();                                  chk("count_saturates",   0,0,0,0,0,3);
    @(negedge clk); #1; rst_n = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b0 || stallCount !== '0 || Fa !== 1'b0 || Fb !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: stall=%b cnt=%0d Fa=%b Fb=%b", stall, stallCount, Fa, Fb);
    end
    tick(); branchFlag = 1'b1; id(2, 2, 5, 1, 0, 1);
                                             chk("reset_mid_stall",   0,1,0,0,0,0);
    tick(); rst_n = 1'b1; branchFlag = 1'b0; chk("reset_release",     0,0,0,0,0,0);
    tick(); id(0, 0, 0, 0, 0, 0);            chk("no_fwd_after_rst",  0,0,0,0,0,0);
    tick();
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d expectations never compared", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
